pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Sequences the 5-stage pipeline: per-stage write enables and flushes in response to debug commands (run/step/halt).
//  Merges the load-use stall request and the taken-branch flush into one consistent control set.
//  When a HALT instruction is decoded, drains the instructions still in flight, then signals done.
//  Sits between the debug unit, hazard detection, branch resolution and all pipeline registers.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles after HALT leaves ID so EX/MEM/WB retire (>=1)
//  NB_CYCLE_CNT  32  width of executed-cycle counter
// PORTS
//  i_clk           in   1   clock, rising edge
//  i_rst_n         in   1   reset, asynchronous, active-low
//  i_cmd_run       in   1   debug pulse: free-run
//  i_cmd_step      in   1   debug pulse: execute exactly one cycle
//  i_cmd_halt      in   1   debug pulse: freeze immediately
//  i_hazard_stall  in   1   load-use stall request (comb, same cycle)
//  i_branch_taken  in   1   branch/jump resolved taken in EX (comb)
//  i_halt_decoded  in   1   HALT opcode present in ID stage
//  o_pc_en         out  1   PC write enable
//  o_if_id_en      out  1   IF/ID write enable
//  o_id_ex_en      out  1   ID/EX write enable
//  o_ex_mem_en     out  1   EX/MEM write enable
//  o_mem_wb_en     out  1   MEM/WB write enable
//  o_if_id_flush   out  1   load NOP into IF/ID
//  o_id_ex_flush   out  1   load NOP (control zeroed) into ID/EX
//  o_state         out  3   current FSM state encoding
//  o_done          out  1   one-cycle pulse: drain complete
//  o_cycle_cnt     out  NB_CYCLE_CNT  executed-cycle count
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, drain cnt=0, cycle cnt=0; all en/flush/o_done=0.
//  - States: IDLE(0) RUN(1) STEP(2) DRAIN(3) DONE(4). State registered; outputs comb decode of state+inputs, same cycle.
//  - Cmd priority same cycle: halt > step > run. Cmds ignored in DRAIN/DONE.
//  - IDLE: all en=0. run->RUN; step->STEP.
//  - RUN: "active" cycle. halt cmd->IDLE; the halt cycle itself is frozen (all en=0).
//  - STEP: one active cycle, then ->IDLE; halt cmd in STEP->IDLE with no active cycle.
//  - Active cycle, base: all five en=1, flushes=0.
//  - Active + i_hazard_stall & !i_branch_taken:
//    pc_en=0, if_id_en=0, id_ex_flush=1; later stages en=1. A stalled STEP still consumes the step.
//  - Active + i_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1. Branch wins over stall; the stalled instr is wrong-path.
//  - Active + i_halt_decoded & !branch & !stall: pc_en=if_id_en=0, id_ex_flush=1, rest en=1;
//    load drain cnt=DRAIN_CYCLES-1; ->DRAIN. HALT under branch is wrong-path: ignored.
//  - DRAIN: pc_en=if_id_en=0, id_ex_flush=1, id_ex/ex_mem/mem_wb en=1; hazard/branch inputs ignored.
//    cnt==0 -> DONE with o_done=1 that transition cycle; else cnt--.
//  - DONE: all en=0, sticky until reset.
//  - Cycle cnt: +1 per active or DRAIN cycle; wraps at 2^NB_CYCLE_CNT.
//  - Reset mid-DRAIN: drain aborted, no o_done.
// CONFIGURATION
//  PIPE_SEQ_CYCLE_CNT_EN defined: cycle counter implemented as above.
//  Not defined: no counter regs; o_cycle_cnt tied to 0.
// STRUCTURE
//  pipeline_pkg: state encodings (ST_IDLE..ST_DONE), DRAIN_CYCLES default, stage-index constants.
//  Sub-module seq_drain_counter: load/decrement/zero-flag down-counter, async active-low reset.
//  Top = FSM + output decode + optional cycle counter.
// TESTING
//  1 reset low mid-RUN -> all outputs 0 same cycle, o_state=0 after release.
//  2 step pulse from IDLE -> exactly 1 cycle all en=1, then IDLE; o_cycle_cnt=1.
//  3 RUN + hazard_stall 1 cycle -> pc_en=if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
//  4 RUN + stall & branch same cycle -> pc_en=1, both flushes=1.
//  5 RUN, halt_decoded at t0 (DRAIN_CYCLES=3) -> DRAIN t1..t3, o_done=1 at t3, DONE t4; later run ignored.
//  6 run+halt same cycle in IDLE -> stays IDLE; halt pulse in RUN -> IDLE, en=0 that cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer slice.
//   seq_state_e      : FSM state encodings, visible on o_state of the top
//   DRAIN_CYCLES_DEF : default number of cycles EX/MEM/WB need to retire after HALT leaves ID
//   EN_*             : bit positions of the five pipeline write enables in an enable vector
//   drain_cnt_width  : width of the drain down-counter for a given drain length
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;

  // Enable vector positions: PC register and the four inter-stage registers.
  localparam int EN_PC     = 0;
  localparam int EN_IF_ID  = 1;
  localparam int EN_ID_EX  = 2;
  localparam int EN_EX_MEM = 3;
  localparam int EN_MEM_WB = 4;
  localparam int NUM_EN    = 5;

  // The counter holds DRAIN_CYCLES-1 down to 0, so clog2(DRAIN_CYCLES) bits suffice.
  function automatic int drain_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/seq_drain_counter.sv
// Load / decrement down-counter with a zero flag, used to time the post-HALT drain.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (count returns to 0)
//   i_load     : load i_load_val (wins over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one; holds at zero
//   o_zero     : count is zero
module seq_drain_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (i_dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_zero = (cnt == '0);

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: turns debug commands (run/step/halt), the load-use stall and the
// taken-branch flush into one consistent set of per-stage write enables and flushes, and
// drains the pipeline after a HALT instruction reaches ID.
//   i_clk, i_rst_n        : clock (rising edge), asynchronous active-low reset
//   i_cmd_run/step/halt   : single-cycle debug command pulses (halt > step > run)
//   i_hazard_stall        : load-use stall request, same cycle
//   i_branch_taken        : branch/jump resolved taken in EX, same cycle
//   i_halt_decoded        : HALT opcode sits in ID
//   o_pc_en .. o_mem_wb_en: write enables of PC and the four pipeline registers
//   o_if_id_flush         : load a NOP into IF/ID
//   o_id_ex_flush         : load a NOP (control zeroed) into ID/EX
//   o_state               : current FSM state (seq_state_e encoding)
//   o_done                : one-cycle pulse when the drain completes
//   o_cycle_cnt           : executed (active + drain) cycle count, wrapping
// Build option: define PIPE_SEQ_CYCLE_CNT_EN to implement the cycle counter; otherwise
// o_cycle_cnt is tied to zero and no counter registers exist.
// All command inputs are level-sampled pulses: a command counts in every cycle it is high,
// and there is no acknowledge; outputs are a combinational decode of state and inputs.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int NB_CYCLE_CNT = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cmd_run,
  input  logic                    i_cmd_step,
  input  logic                    i_cmd_halt,
  input  logic                    i_hazard_stall,
  input  logic                    i_branch_taken,
  input  logic                    i_halt_decoded,
  output logic                    o_pc_en,
  output logic                    o_if_id_en,
  output logic                    o_id_ex_en,
  output logic                    o_ex_mem_en,
  output logic                    o_mem_wb_en,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_flush,
  output logic [2:0]              o_state,
  output logic                    o_done,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_cnt
);

  localparam int DRAIN_W = drain_cnt_width(DRAIN_CYCLES);

  seq_state_e        state, state_next;
  logic [NUM_EN-1:0] en;
  logic              if_id_flush, id_ex_flush, done;
  logic              drain_load, drain_dec, drain_zero;
  logic              active;

  // A RUN/STEP cycle executes unless a halt command freezes that very cycle.
  assign active = ((state == ST_RUN) || (state == ST_STEP)) && !i_cmd_halt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    en          = '0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    done        = 1'b0;
    drain_load  = 1'b0;
    drain_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_cmd_halt)      state_next = ST_IDLE;
        else if (i_cmd_step) state_next = ST_STEP;
        else if (i_cmd_run)  state_next = ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        if (i_cmd_halt) begin
          state_next = ST_IDLE;
        end else begin
          en = '1;
          if (state == ST_STEP) state_next = ST_IDLE;
          // Branch beats stall and HALT: whatever sits in IF/ID and ID is wrong-path.
          if (i_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (i_hazard_stall) begin
            en[EN_PC]    = 1'b0;
            en[EN_IF_ID] = 1'b0;
            id_ex_flush  = 1'b1;
          end else if (i_halt_decoded) begin
            // HALT is held in ID; a bubble goes to EX while the older work retires.
            en[EN_PC]    = 1'b0;
            en[EN_IF_ID] = 1'b0;
            id_ex_flush  = 1'b1;
            drain_load   = 1'b1;
            state_next   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        en[EN_ID_EX]  = 1'b1;
        en[EN_EX_MEM] = 1'b1;
        en[EN_MEM_WB] = 1'b1;
        id_ex_flush   = 1'b1;
        if (drain_zero) begin
          done       = 1'b1;
          state_next = ST_DONE;
        end else begin
          drain_dec = 1'b1;
        end
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  seq_drain_counter #(.W(DRAIN_W)) u_drain_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (drain_load),
    .i_load_val (DRAIN_W'(DRAIN_CYCLES - 1)),
    .i_dec      (drain_dec),
    .o_zero     (drain_zero)
  );

`ifdef PIPE_SEQ_CYCLE_CNT_EN
  logic [NB_CYCLE_CNT-1:0] cycle_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt <= '0;
    end else if (active || (state == ST_DRAIN)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign o_cycle_cnt = cycle_cnt;
`else
  assign o_cycle_cnt = '0;
`endif

  assign o_pc_en       = en[EN_PC];
  assign o_if_id_en    = en[EN_IF_ID];
  assign o_id_ex_en    = en[EN_ID_EX];
  assign o_ex_mem_en   = en[EN_EX_MEM];
  assign o_mem_wb_en   = en[EN_MEM_WB];
  assign o_if_id_flush = if_id_flush;
  assign o_id_ex_flush = id_ex_flush;
  assign o_done        = done;
  assign o_state       = state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed command/hazard vectors, a per-cycle behavioural
// model feeding an expected queue, and hand-computed literal expectations per scenario.
module tb_pipeline_sequencer;

  localparam int DRAIN_CYCLES = 3;
  localparam int NB           = 32;
  localparam int W            = 8 + 3 + NB;

`ifdef PIPE_SEQ_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_run, cmd_step, cmd_halt, hazard_stall, branch_taken, halt_decoded;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [2:0]    state;
  logic          done;
  logic [NB-1:0] cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .NB_CYCLE_CNT(NB)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_run      (cmd_run),
    .i_cmd_step     (cmd_step),
    .i_cmd_halt     (cmd_halt),
    .i_hazard_stall (hazard_stall),
    .i_branch_taken (branch_taken),
    .i_halt_decoded (halt_decoded),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_id_ex_en     (id_ex_en),
    .o_ex_mem_en    (ex_mem_en),
    .o_mem_wb_en    (mem_wb_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_state        (state),
    .o_done         (done),
    .o_cycle_cnt    (cycle_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; literal checks sample 3 units after it.
  task automatic drive(input logic run, input logic step, input logic halt,
                       input logic stall, input logic br, input logic hd);
    @(posedge clk);
    #1;
    cmd_run      = run;
    cmd_step     = step;
    cmd_halt     = halt;
    hazard_stall = stall;
    branch_taken = br;
    halt_decoded = hd;
    #2;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Mode: 0 idle, 1 free-running, 2 single step pending, 3 draining, 4 finished.
  int          m_mode  = 0;
  int          m_drain = 0;   // drain cycles still to go, including the current one
  logic [NB-1:0] m_cnt = '0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    logic       e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf, e_done;
    logic       executes;
    int         next_mode;
    logic [W-1:0] e_vec, a_vec, q_vec;
    e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
    e_iff = 0; e_idf = 0; e_done = 0;
    executes  = 1'b0;
    next_mode = m_mode;
    if (!rst_n) begin
      m_mode  = 0;
      m_drain = 0;
      m_cnt   = '0;
      next_mode = 0;
    end else if (m_mode == 0) begin
      if (!cmd_halt && cmd_step)     next_mode = 2;
      else if (!cmd_halt && cmd_run) next_mode = 1;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (cmd_halt) begin
        next_mode = 0;
      end else begin
        executes = 1'b1;
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        next_mode = (m_mode == 2) ? 0 : 1;
        if (branch_taken) begin
          e_iff = 1; e_idf = 1;
        end else if (hazard_stall) begin
          e_pc = 0; e_ifid = 0; e_idf = 1;
        end else if (halt_decoded) begin
          e_pc = 0; e_ifid = 0; e_idf = 1;
          m_drain   = DRAIN_CYCLES;
          next_mode = 3;
        end
      end
    end else if (m_mode == 3) begin
      executes = 1'b1;
      e_idex = 1; e_exmem = 1; e_memwb = 1; e_idf = 1;
      m_drain--;
      if (m_drain == 0) begin
        e_done    = 1;
        next_mode = 4;
      end
    end
    e_vec = {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf, e_done,
             3'(m_mode), (CNT_EN ? m_cnt : {NB{1'b0}})};
    exp_q.push_back(e_vec);
    if (executes) m_cnt = m_cnt + 1'b1;
    m_mode = next_mode;
    a_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
             done, state, cycle_cnt};
    q_vec = exp_q.pop_front();
    chk("cycle_ctl", 64'(a_vec), 64'(q_vec));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  logic [2:0] vec_tbl [8];

  initial begin
    rst_n = 1'b0;
    cmd_run = 0; cmd_step = 0; cmd_halt = 0;
    hazard_stall = 0; branch_taken = 0; halt_decoded = 0;
    // {stall, branch, halt_decoded} patterns applied while free-running
    vec_tbl[0] = 3'b000; vec_tbl[1] = 3'b100; vec_tbl[2] = 3'b010; vec_tbl[3] = 3'b110;
    vec_tbl[4] = 3'b011; vec_tbl[5] = 3'b101; vec_tbl[6] = 3'b111; vec_tbl[7] = 3'b000;
    #2;
    chk("rst_state", state, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cycle_cnt, 0);
    release_reset();

    // Single step from IDLE
    drive(0, 1, 0, 0, 0, 0);
    chk("step_idle_state", state, 0);
    chk("step_idle_pc_en", pc_en, 0);
    idle_cycle();
    chk("step_state", state, 2);
    chk("step_all_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    chk("step_flushes", {if_id_flush, id_ex_flush}, 2'b00);
    idle_cycle();
    chk("step_back_idle", state, 0);
    chk("step_idle_en", pc_en, 0);
    chk("step_cnt", cycle_cnt, CNT_EN ? 1 : 0);

    // Stall while running
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("stall_state", state, 1);
    chk("stall_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00111);
    chk("stall_flush", {if_id_flush, id_ex_flush}, 2'b01);
    // Stall and branch together: branch wins
    drive(0, 0, 0, 1, 1, 0);
    chk("br_stall_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    chk("br_stall_flush", {if_id_flush, id_ex_flush}, 2'b11);
    // HALT under branch is wrong-path
    drive(0, 0, 0, 0, 1, 1);
    chk("br_hd_pc_en", pc_en, 1);
    idle_cycle();
    chk("br_hd_still_run", state, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, vec_tbl[i][2], vec_tbl[i][1], vec_tbl[i][0]);
    end
    // Halt command in RUN freezes that cycle
    drive(0, 0, 1, 0, 0, 0);
    chk("halt_cmd_state", state, 1);
    chk("halt_cmd_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
    idle_cycle();
    chk("halt_cmd_idle", state, 0);
    // run + halt in IDLE: halt wins
    drive(1, 0, 1, 0, 0, 0);
    idle_cycle();
    chk("run_halt_idle", state, 0);
    chk("run_halt_en", pc_en, 0);
    // Stalled step still consumes the step
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("step_stall_state", state, 2);
    chk("step_stall_pc_en", pc_en, 0);
    chk("step_stall_flush", id_ex_flush, 1);
    idle_cycle();
    chk("step_stall_idle", state, 0);

    // Reset mid-RUN
    drive(1, 0, 0, 0, 0, 0);
    idle_cycle();
    chk("run_pc_en", pc_en, 1);
    apply_reset();
    chk("rst_run_state", state, 0);
    chk("rst_run_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
    chk("rst_run_cnt", cycle_cnt, 0);
    release_reset();
    idle_cycle();
    chk("rst_run_after", state, 0);

    // HALT decode and drain
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("hd_t0_state", state, 1);
    chk("hd_t0_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00111);
    chk("hd_t0_flush", {if_id_flush, id_ex_flush}, 2'b01);
    drive(0, 0, 0, 1, 1, 0);
    chk("drain_t1_state", state, 3);
    chk("drain_t1_out", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, done}, 6'b001010);
    drive(1, 1, 1, 0, 0, 0);
    chk("drain_t2_state", state, 3);
    chk("drain_t2_done", done, 0);
    idle_cycle();
    chk("drain_t3_state", state, 3);
    chk("drain_t3_done", done, 1);
    drive(1, 0, 0, 0, 0, 0);
    chk("done_t4_state", state, 4);
    chk("done_t4_out", {pc_en, id_ex_en, mem_wb_en, done}, 4'b0000);
    idle_cycle();
    chk("done_sticky", state, 4);
    chk("done_cnt", cycle_cnt, CNT_EN ? 4 : 0);
    apply_reset();
    chk("rst_done_state", state, 0);
    release_reset();

    // Reset mid-DRAIN: no done pulse
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle_cycle();
    idle_cycle();
    chk("mid_drain_state", state, 3);
    apply_reset();
    chk("mid_drain_rst_done", done, 0);
    chk("mid_drain_rst_state", state, 0);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("mid_drain_no_done", done, 0);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
